param_stack_calc: RTL and testbench

PARAM_STACK_CALC -- requirements
Module: param_stack_calc

---
 rtl/param_stack_calc.sv | 232 +++++++++++++++++++++++
 tb/tb_param_stack_calc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stack_calc.sv
// Parameterised stack calculator: IDLE/EXEC(/WB2) sequencer over a DEPTH x WIDTH stack.
// Define PARAM_STACK_CALC_MULDIV_EN to build the multiply/divide path with its WB2 state.
module param_stack_calc #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [3:0]                 opcode,
    input  logic [WIDTH-1:0]           operand,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           second,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [2*WIDTH-1:0]         out_reg,
    output logic                       carry_flag,
    output logic                       error_flag
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB2  = 2'd2;

    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_OUTL = 4'h3;
    localparam logic [3:0] OP_OUTH = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;
    localparam logic [3:0] OP_DUP  = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_MULT = 4'h9;
    localparam logic [3:0] OP_DIV  = 4'hA;
    localparam logic [3:0] OP_CLFL = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        depth_q, depth_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 carry_q, carry_d;
    logic                 err_q, err_d;
    logic [3:0]           opc_q;
    logic [WIDTH-1:0]     opd_q;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic                 wa_en, wb_en;
    logic [IW-1:0]        wa_idx, wb_idx;
    logic [WIDTH-1:0]     wa_val, wb_val;

    logic [IW-1:0]        idx0, idx1, idx_free;
    logic [WIDTH-1:0]     v0, v1;
    logic                 has1, has2, full;
    logic [WIDTH:0]       sum, diff;

`ifdef PARAM_STACK_CALC_MULDIV_EN
    logic [WIDTH-1:0]     res_q, res_d;
    logic [2*WIDTH-1:0]   prod;
`endif

    assign idx0     = IW'(depth_q - PW'(1));
    assign idx1     = IW'(depth_q - PW'(2));
    assign idx_free = IW'(depth_q);
    assign v0       = mem_q[idx0];
    assign v1       = mem_q[idx1];
    assign has1     = (depth_q >= PW'(1));
    assign has2     = (depth_q >= PW'(2));
    assign full     = (depth_q == PW'(DEPTH));
    assign sum      = {1'b0, v1} + {1'b0, v0};
    // Bit WIDTH of the widened difference is the borrow, i.e. v1 < v0.
    assign diff     = {1'b0, v1} - {1'b0, v0};

    assign op_ready   = (state_q == S_IDLE);
    assign top        = has1 ? v0 : '0;
    assign second     = has2 ? v1 : '0;
    assign depth      = depth_q;
    assign out_reg    = out_q;
    assign carry_flag = carry_q;
    assign error_flag = err_q;

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        out_d   = out_q;
        carry_d = carry_q;
        err_d   = err_q;
        wa_en   = 1'b0;
        wa_idx  = idx0;
        wa_val  = v0;
        wb_en   = 1'b0;
        wb_idx  = idx1;
        wb_val  = v1;
`ifdef PARAM_STACK_CALC_MULDIV_EN
        res_d   = res_q;
        prod    = {{WIDTH{1'b0}}, v1} * {{WIDTH{1'b0}}, v0};
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (opc_q)
                    OP_PUSH: begin
                        if (full) err_d = 1'b1;
                        else begin
                            wa_en = 1'b1; wa_idx = idx_free; wa_val = opd_q;
                            depth_d = depth_q + PW'(1);
                        end
                    end
                    OP_POP: begin
                        if (!has1) err_d = 1'b1;
                        else depth_d = depth_q - PW'(1);
                    end
                    OP_OUTL: begin
                        if (!has1) err_d = 1'b1;
                        else out_d[WIDTH-1:0] = v0;
                    end
                    OP_OUTH: begin
                        if (!has1) err_d = 1'b1;
                        else out_d[2*WIDTH-1:WIDTH] = v0;
                    end
                    OP_SWAP: begin
                        if (!has2) err_d = 1'b1;
                        else begin
                            wa_en = 1'b1; wa_val = v1;
                            wb_en = 1'b1; wb_val = v0;
                        end
                    end
                    OP_DUP: begin
                        if (!has1 || full) err_d = 1'b1;
                        else begin
                            wa_en = 1'b1; wa_idx = idx_free; wa_val = v0;
                            depth_d = depth_q + PW'(1);
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        if (!has2) err_d = 1'b1;
                        else begin
                            wb_en   = 1'b1;
                            depth_d = depth_q - PW'(1);
                            case (opc_q)
                                OP_ADD:  begin wb_val = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  end
                                OP_SUB:  begin wb_val = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
                                OP_AND:  wb_val = v1 & v0;
                                OP_OR:   wb_val = v1 | v0;
                                default: wb_val = v1 ^ v0;
                            endcase
                        end
                    end
                    OP_NOT: begin
                        if (!has1) err_d = 1'b1;
                        else begin
                            wa_en = 1'b1; wa_val = ~v0;
                        end
                    end
                    OP_CLFL: begin
                        carry_d = 1'b0;
                        err_d   = 1'b0;
                    end
`ifdef PARAM_STACK_CALC_MULDIV_EN
                    // Low half / remainder lands now; the high half / quotient follows in WB2.
                    OP_MULT: begin
                        if (!has2) err_d = 1'b1;
                        else begin
                            wb_en = 1'b1; wb_val = prod[WIDTH-1:0];
                            depth_d = depth_q - PW'(1);
                            res_d   = prod[2*WIDTH-1:WIDTH];
                            state_d = S_WB2;
                        end
                    end
                    OP_DIV: begin
                        if (!has2 || v0 == '0) err_d = 1'b1;
                        else begin
                            wb_en = 1'b1; wb_val = v1 % v0;
                            depth_d = depth_q - PW'(1);
                            res_d   = v1 / v0;
                            state_d = S_WB2;
                        end
                    end
`else
                    OP_MULT, OP_DIV: err_d = 1'b1;
`endif
                    default: ;
                endcase
            end
`ifdef PARAM_STACK_CALC_MULDIV_EN
            S_WB2: begin
                state_d = S_IDLE;
                wa_en   = 1'b1; wa_idx = idx_free; wa_val = res_q;
                depth_d = depth_q + PW'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Datapath storage carries no reset; the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (op_valid && op_ready && !rst) begin
            opc_q <= opcode;
            opd_q <= operand;
        end
        if (!rst && wa_en) mem_q[wa_idx] <= wa_val;
        if (!rst && wb_en) mem_q[wb_idx] <= wb_val;
`ifdef PARAM_STACK_CALC_MULDIV_EN
        res_q <= res_d;
`endif
    end

endmodule

// File: tb/tb_param_stack_calc.sv
// Directed self-checking bench for param_stack_calc (WIDTH=4, DEPTH=8).
module tb_param_stack_calc;
    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] top, second;
    logic [3:0] depth;
    logic [7:0] out_reg;
    logic       carry_flag, error_flag;

    int n_checks = 0;
    int n_errors = 0;
    int lc;

    localparam logic [3:0] NOOP = 4'h0, PUSH = 4'h1, POP = 4'h2, OUTL = 4'h3, OUTH = 4'h4,
                           SWAP = 4'h5, DUP = 4'h6, ADD = 4'h7, SUB = 4'h8, MULT = 4'h9,
                           DIV = 4'hA, CLFL = 4'hB, AND_ = 4'hC, OR_ = 4'hD, XOR_ = 4'hE,
                           NOT_ = 4'hF;

    param_stack_calc #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .top(top), .second(second),
        .depth(depth), .out_reg(out_reg), .carry_flag(carry_flag), .error_flag(error_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op for a single cycle and wait until the block is idle again;
    // low_cnt returns the number of sampled cycles op_ready stayed low.
    task automatic do_op(input logic [3:0] opc, input logic [3:0] opd, output int low_cnt);
        int n;
        @(negedge clk);
        opcode = opc; operand = opd; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("op_timeout", 32'(op_ready), 32'd1);
        low_cnt = n;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; opcode = NOOP; operand = '0;
        repeat (2) @(negedge clk);
        check("rst_depth", 32'(depth), 0);
        check("rst_top", 32'(top), 0);
        check("rst_second", 32'(second), 0);
        check("rst_out", 32'(out_reg), 0);
        check("rst_carry", 32'(carry_flag), 0);
        check("rst_err", 32'(error_flag), 0);
        check("rst_ready", 32'(op_ready), 1);
        rst = 1'b0;

        // 3 + 5
        do_op(PUSH, 4'h3, lc);
        do_op(PUSH, 4'h5, lc);
        do_op(ADD, 4'h0, lc);
        check("add_top", 32'(top), 32'h8);
        check("add_depth", 32'(depth), 1);
        check("add_carry", 32'(carry_flag), 0);
        check("add_err", 32'(error_flag), 0);
        check("single_low", 32'(lc), 1);

        // carry and borrow
        apply_reset();
        do_op(PUSH, 4'hF, lc);
        do_op(PUSH, 4'h2, lc);
        do_op(ADD, 4'h0, lc);
        check("addc_top", 32'(top), 32'h1);
        check("addc_carry", 32'(carry_flag), 1);
        do_op(PUSH, 4'h2, lc);
        do_op(PUSH, 4'h5, lc);
        do_op(SUB, 4'h0, lc);
        check("sub_top", 32'(top), 32'hD);
        check("sub_second", 32'(second), 32'h1);
        check("sub_borrow", 32'(carry_flag), 1);
        do_op(CLFL, 4'h0, lc);
        check("clfl_carry", 32'(carry_flag), 0);

        // overflow and underflow
        apply_reset();
        for (int i = 1; i <= 9; i++) do_op(PUSH, 4'(i), lc);
        check("ovf_depth", 32'(depth), 8);
        check("ovf_top", 32'(top), 32'h8);
        check("ovf_err", 32'(error_flag), 1);
        do_op(CLFL, 4'h0, lc);
        check("clfl_err", 32'(error_flag), 0);
        for (int i = 0; i < 8; i++) do_op(POP, 4'h0, lc);
        check("pop8_depth", 32'(depth), 0);
        check("pop8_err", 32'(error_flag), 0);
        do_op(POP, 4'h0, lc);
        check("unf_depth", 32'(depth), 0);
        check("unf_err", 32'(error_flag), 1);

        // out latch and unary/logic ops
        apply_reset();
        do_op(PUSH, 4'hA, lc);
        do_op(OUTL, 4'h0, lc);
        do_op(PUSH, 4'h5, lc);
        do_op(OUTH, 4'h0, lc);
        check("out_reg", 32'(out_reg), 32'h5A);
        do_op(SWAP, 4'h0, lc);
        check("swap_top", 32'(top), 32'hA);
        check("swap_second", 32'(second), 32'h5);
        do_op(DUP, 4'h0, lc);
        check("dup_depth", 32'(depth), 3);
        do_op(NOT_, 4'h0, lc);
        check("not_top", 32'(top), 32'h5);
        do_op(OR_, 4'h0, lc);
        check("or_top", 32'(top), 32'hF);
        do_op(XOR_, 4'h0, lc);
        check("xor_top", 32'(top), 32'hA);
        do_op(AND_, 4'h0, lc);
        check("and_unf_top", 32'(top), 32'hA);
        check("and_unf_depth", 32'(depth), 1);
        check("and_unf_err", 32'(error_flag), 1);

`ifdef PARAM_STACK_CALC_MULDIV_EN
        apply_reset();
        do_op(PUSH, 4'h7, lc);
        do_op(PUSH, 4'h3, lc);
        do_op(MULT, 4'h0, lc);
        check("mult_top", 32'(top), 32'h1);
        check("mult_second", 32'(second), 32'h5);
        check("mult_depth", 32'(depth), 2);
        check("mult_low", 32'(lc), 2);
        check("mult_err", 32'(error_flag), 0);
        apply_reset();
        do_op(PUSH, 4'h7, lc);
        do_op(PUSH, 4'h3, lc);
        do_op(DIV, 4'h0, lc);
        check("div_top", 32'(top), 32'h2);
        check("div_second", 32'(second), 32'h1);
        apply_reset();
        do_op(PUSH, 4'h4, lc);
        do_op(PUSH, 4'h0, lc);
        do_op(DIV, 4'h0, lc);
        check("div0_top", 32'(top), 32'h0);
        check("div0_second", 32'(second), 32'h4);
        check("div0_depth", 32'(depth), 2);
        check("div0_err", 32'(error_flag), 1);
        check("div0_low", 32'(lc), 1);
`else
        apply_reset();
        do_op(PUSH, 4'h7, lc);
        do_op(PUSH, 4'h3, lc);
        do_op(MULT, 4'h0, lc);
        check("nomult_top", 32'(top), 32'h3);
        check("nomult_second", 32'(second), 32'h7);
        check("nomult_err", 32'(error_flag), 1);
        check("nomult_low", 32'(lc), 1);
`endif

        // op_valid held high: accept and execute alternate
        apply_reset();
        @(negedge clk);
        opcode = PUSH; operand = 4'hA; op_valid = 1'b1;
        repeat (8) @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("hold_depth", 32'(depth), 4);
        check("hold_top", 32'(top), 32'hA);

        // reset while the multiply is in flight
        apply_reset();
        do_op(PUSH, 4'h7, lc);
        do_op(OUTL, 4'h0, lc);
        do_op(PUSH, 4'h3, lc);
        @(negedge clk);
        opcode = MULT; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_depth", 32'(depth), 0);
        check("abort_top", 32'(top), 0);
        check("abort_second", 32'(second), 0);
        check("abort_out", 32'(out_reg), 0);
        check("abort_ready", 32'(op_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_after_depth", 32'(depth), 0);
        check("abort_after_err", 32'(error_flag), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
